// File: rtl/cmd_uart_responder.sv
// Remote-command UART endpoint: 2-byte command receiver with assembly FSM and 1-byte response transmitter.
// Optional build macro CMD_TIMEOUT_EN: abandons a half-received command after TIMEOUT_CYC idle clocks.
module cmd_uart_responder #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_s1, rx_s2, rx_s3;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             start_edge, half_hit, baud_hit;
    logic             start_det, rx_cnt_clr, rx_sample, rx_rdy;

    asm_state_t       asm_state, asm_next;
    logic [7:0]       hi_byte;
    logic             ld_hi, ld_cmd, drop_rdy, timeout;

    tx_state_t        tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [9:0]       tx_shift;
    logic             tx_baud_hit, tx_load, tx_adv, tx_end;

    // Synchroniser plus one history flop for falling-edge detection; idle level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;
    assign half_hit   = (rx_cnt == HALF_LAST);
    assign baud_hit   = (rx_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (start_edge) rx_next = RX_START;
            RX_START: if (half_hit) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_hit && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (baud_hit) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        start_det  = (rx_state == RX_IDLE) && start_edge;
        rx_cnt_clr = (rx_state == RX_IDLE) ||
                     ((rx_state == RX_START) && half_hit) ||
                     ((rx_state == RX_DATA) && baud_hit);
        rx_sample  = (rx_state == RX_DATA) && baud_hit;
        rx_rdy     = (rx_state == RX_STOP) && baud_hit && rx_s2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            else if (rx_sample)
                rx_bit <= rx_bit + 1'b1;
            if (rx_sample)
                rx_shift <= {rx_s2, rx_shift[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) asm_state <= WAIT_HI;
        else     asm_state <= asm_next;
    end

    always_comb begin
        asm_next = asm_state;
        case (asm_state)
            WAIT_HI: if (rx_rdy) asm_next = WAIT_LO;
            WAIT_LO: if (rx_rdy || timeout) asm_next = WAIT_HI;
            default: asm_next = WAIT_HI;
        endcase
    end

    always_comb begin
        ld_hi    = (asm_state == WAIT_HI) && rx_rdy;
        ld_cmd   = (asm_state == WAIT_LO) && rx_rdy;
        drop_rdy = (asm_state == WAIT_HI) && start_det;
    end

    // A completed frame takes priority over any clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_byte <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (ld_hi)
                hi_byte <= rx_shift;
            else if (timeout)
                hi_byte <= '0;
            if (ld_cmd)
                cmd <= {hi_byte, rx_shift};
            if (ld_cmd)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || drop_rdy)
                cmd_rdy <= 1'b0;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt;
    logic            to_run;

    // Runs from entry into WAIT_LO until the low byte's start bit shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_run <= 1'b0;
        end else if (ld_hi) begin
            to_cnt <= '0;
            to_run <= 1'b1;
        end else if ((asm_state == WAIT_LO) && to_run) begin
            if (start_det || timeout)
                to_run <= 1'b0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (asm_state == WAIT_LO) && to_run && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    assign tx_baud_hit = (tx_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (trmt) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_baud_hit && tx_bit == 4'd9) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_load = (tx_state == TX_IDLE) && trmt;
        tx_adv  = (tx_state == TX_SHIFT) && tx_baud_hit;
        tx_end  = tx_adv && (tx_bit == 4'd9);
    end

    // Shifter refills with 1s so TX comes straight from a flop and idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= {1'b1, resp, 1'b0};
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else if (tx_adv) begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 1'b1;
            if (tx_end)
                tx_done <= 1'b1;
        end else if (tx_state == TX_SHIFT) begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign TX = tx_shift[0];

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Directed bench for cmd_uart_responder at a reduced baud divisor; expectations adapt to CMD_TIMEOUT_EN.
module tb_cmd_uart_responder;

    localparam int B    = 32;
    localparam int HALF = B / 2;
    localparam int TO   = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    logic [9:0] frame;

    cmd_uart_responder #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit, then one idle bit time.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(B);
        end
        RX = stop;
        tick(B);
        RX = 1'b1;
        tick(B);
    endtask

    // Runs alongside send_byte of a low byte: cmd_rdy must rise exactly 3+HALF+9B edges after the start edge.
    task automatic watch_low(input string tag, input logic [15:0] exp, input logic force_clr);
        tick(2 + HALF + 9 * B);
        check({tag, "_rdy_before"}, 16'(cmd_rdy), 16'h0);
        if (force_clr) clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check({tag, "_rdy_set"}, 16'(cmd_rdy), 16'h1);
        check({tag, "_cmd"}, cmd, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = 8'h00;
        tick(3);
        check("reset_tx", 16'(TX), 16'h1);
        check("reset_cmd", cmd, 16'h0);
        check("reset_rdy", 16'(cmd_rdy), 16'h0);
        check("reset_done", 16'(tx_done), 16'h0);
        rst = 1'b0;
        tick(2);

        // Frame 0x2B, 0xF1
        send_byte(8'h2B, 1'b1);
        check("f1_hi_only_rdy", 16'(cmd_rdy), 16'h0);
        check("f1_tx_idle", 16'(TX), 16'h1);
        fork
            send_byte(8'hF1, 1'b1);
            watch_low("f1", 16'h2BF1, 1'b0);
        join
        check("f1_tx_idle_end", 16'(TX), 16'h1);

        // Response 0xA5 with an ignored trmt at mid-frame
        frame = {1'b1, 8'hA5, 1'b0};
        trmt = 1'b1; resp = 8'hA5;
        tick(1);
        trmt = 1'b0;
        check("tx_done_cleared", 16'(tx_done), 16'h0);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("tx_bit%0d_first", j), 16'(TX), 16'(frame[j]));
            if (j == 4) begin
                trmt = 1'b1; resp = 8'h00;
                tick(1);
                trmt = 1'b0;
                tick(B - 2);
            end else begin
                tick(B - 1);
            end
            check($sformatf("tx_bit%0d_last", j), 16'(TX), 16'(frame[j]));
            if (j == 9) check("tx_done_before_end", 16'(tx_done), 16'h0);
            tick(1);
        end
        check("tx_done_set", 16'(tx_done), 16'h1);
        check("tx_idle_after", 16'(TX), 16'h1);

        // Clear, then two 0x2001 frames: drop at high start, set beats clear
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", 16'(cmd_rdy), 16'h0);
        check("clr_cmd_kept", cmd, 16'h2BF1);
        send_byte(8'h20, 1'b1);
        fork
            send_byte(8'h01, 1'b1);
            watch_low("f2", 16'h2001, 1'b0);
        join
        fork
            send_byte(8'h20, 1'b1);
            begin
                tick(2);
                check("drop_rdy_before", 16'(cmd_rdy), 16'h1);
                tick(1);
                check("drop_rdy_after", 16'(cmd_rdy), 16'h0);
            end
        join
        fork
            send_byte(8'h01, 1'b1);
            watch_low("f3_setwins", 16'h2001, 1'b1);
        join

        // False start and framing error are both ignored
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        RX = 1'b0;
        tick(10);
        RX = 1'b1;
        tick(3 * B);
        check("false_start_rdy", 16'(cmd_rdy), 16'h0);
        check("false_start_cmd", cmd, 16'h2001);
        send_byte(8'h00, 1'b0);
        check("bad_stop_rdy", 16'(cmd_rdy), 16'h0);
        check("bad_stop_cmd", cmd, 16'h2001);
        send_byte(8'h55, 1'b1);
        check("resync_hi_rdy", 16'(cmd_rdy), 16'h0);
        fork
            send_byte(8'hAA, 1'b1);
            watch_low("f4", 16'h55AA, 1'b0);
        join

        // Reset in the middle of an RX byte and a TX frame
        trmt = 1'b1; resp = 8'h00;
        tick(1);
        trmt = 1'b0;
        check("f5_tx_started", 16'(tx_done), 16'h0);
        fork
            send_byte(8'h99, 1'b1);
            begin
                tick(4 * B);
                check("f5_tx_mid_low", 16'(TX), 16'h0);
                rst = 1'b1;
                #2;
                check("f5_rst_tx", 16'(TX), 16'h1);
                check("f5_rst_rdy", 16'(cmd_rdy), 16'h0);
                check("f5_rst_done", 16'(tx_done), 16'h0);
                check("f5_rst_cmd", cmd, 16'h0);
            end
        join
        tick(2);
        rst = 1'b0;
        tick(3);
        check("f5_post_tx", 16'(TX), 16'h1);
        check("f5_post_rdy", 16'(cmd_rdy), 16'h0);
        send_byte(8'h27, 1'b1);
        fork
            send_byte(8'hF1, 1'b1);
            watch_low("f5", 16'h27F1, 1'b0);
        join

        // Lost low byte followed by a fresh frame
        send_byte(8'h23, 1'b1);
        tick(600);
        send_byte(8'h23, 1'b1);
        send_byte(8'hF1, 1'b1);
`ifdef CMD_TIMEOUT_EN
        check("f6_cmd", cmd, 16'h23F1);
        check("f6_rdy", 16'(cmd_rdy), 16'h1);
`else
        check("f6_cmd", cmd, 16'h2323);
        check("f6_rdy", 16'(cmd_rdy), 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
